// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants, fetch-buffer entry type and PC helpers for
//                the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_STEP   = 32'd4;
  // Canonical no-op, shown on the instruction bus while the buffer is empty.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // One fetch-buffer entry: byte address of the word and the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address down to its containing word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
//  Module      : instruction_fetch_if
//  Description : Bundle of the fetch stage's memory, decode and redirect
//                signals. The master modport is the fetch stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;

  logic        fetch_enable;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  modport master (
    input  fetch_enable,
    output imem_address,
    input  imem_instruction,
    output if_valid,
    input  if_ready,
    output if_instruction,
    output if_pc,
    input  redirect_valid,
    input  redirect_target,
    output fetch_fault
  );

  modport slave (
    output fetch_enable,
    input  imem_address,
    output imem_instruction,
    input  if_valid,
    output if_ready,
    input  if_instruction,
    input  if_pc,
    output redirect_valid,
    output redirect_target,
    input  fetch_fault
  );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO of {pc, instruction} entries with a
//                single-cycle flush. Pointers wrap naturally at FIFO_DEPTH,
//                which must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  wire                          clk,
  input  wire                          reset,
  input  wire                          push,
  input  wire                          pop,
  input  wire                          flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module      : instruction_fetch
//  Description : Program counter and fetch buffer in front of a combinational
//                instruction memory; hands {pc, instruction} to decode over
//                valid/ready and restarts on redirects with a full flush.
//  Options     : FETCH_MISALIGN_TRAP_EN - misaligned redirect targets raise
//                fetch_fault and stall fetch instead of being aligned down.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  wire                  clk,
  input  wire                  reset,
  instruction_fetch_if.master  bus
);

  logic [31:0]                 pc;
  logic [31:0]                 redirect_pc;
  logic                        fault_hold;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  fetch_entry_t                din;
  fetch_entry_t                dout;

  // A redirect cycle hides the head so decode never consumes a flushed entry.
  assign bus.if_valid     = ~empty & ~bus.redirect_valid;
  assign pop              = bus.if_valid & bus.if_ready;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign push             = bus.fetch_enable & ~bus.redirect_valid & ~fault_hold
                            & (~full | pop);

  assign bus.imem_address   = pc;
  assign din                = '{pc: pc, instr: bus.imem_instruction};
  assign bus.if_pc          = dout.pc;
  assign bus.if_instruction = empty ? INSTR_NOP : dout.instr;
  assign bus.fetch_fault    = fault_hold;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_pc = bus.redirect_target;

  // Fault latches on a misaligned redirect and clears on an aligned one.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_hold <= 1'b0;
    end else if (bus.redirect_valid) begin
      fault_hold <= |bus.redirect_target[1:0];
    end
  end
`else
  assign redirect_pc = align_word(bus.redirect_target);
  assign fault_hold  = 1'b0;
`endif

  // Program counter: reset beats redirect, redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (bus.redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  a_empty_matches_count: assert property (@(posedge clk) disable iff (reset)
    empty == (count == '0));

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch. Two instances
//                (reset vectors 0 and FFFF_FFF8) share one stimulus stream.
//                Each restart pushes the expected sequential pc stream into a
//                per-instance queue; a negedge monitor pops on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        if_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic        exp_fault = 1'b0;
  logic        started = 1'b0;
  int          since_restart = 0;
  logic        prev_stall [2];
  logic [31:0] prev_pc [2];
  logic [31:0] prev_ins [2];
  logic        prev_rst = 1'b1;

  always #5 clk = ~clk;

  // Memory image: two fixed words at the bottom, address-derived elsewhere.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (w == 32'd0) return 32'h3e80_0093;
    if (w == 32'd1) return 32'h7d00_8113;
    return (w * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  instruction_fetch_if bus0 ();
  instruction_fetch_if bus1 ();

  assign bus0.fetch_enable     = fetch_enable;
  assign bus0.if_ready         = if_ready;
  assign bus0.redirect_valid   = redirect_valid;
  assign bus0.redirect_target  = redirect_target;
  assign bus0.imem_instruction = mem_f(bus0.imem_address);
  assign bus1.fetch_enable     = fetch_enable;
  assign bus1.if_ready         = if_ready;
  assign bus1.redirect_valid   = redirect_valid;
  assign bus1.redirect_target  = redirect_target;
  assign bus1.imem_instruction = mem_f(bus1.imem_address);

  instruction_fetch #(.RESET_VECTOR(RV0), .FIFO_DEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  instruction_fetch #(.RESET_VECTOR(RV1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected stream after a restart: consecutive words from the start pc.
  task automatic restart(input logic [31:0] b0, input logic [31:0] b1);
    q0.delete();
    q1.delete();
    for (int k = 0; k < 200; k++) begin
      q0.push_back(b0 + 32'(4 * k));
      q1.push_back(b1 + 32'(4 * k));
    end
    since_restart = 0;
  endtask

  // One clock: fold last cycle's controls into the model, then drive new ones.
  task automatic cycle(input bit rst, input bit en, input bit rdy, input bit rv,
                       input logic [31:0] tgt);
    @(posedge clk);
    #1;
    since_restart++;
    if (reset) begin
      restart(RV0, RV1);
      exp_fault = 1'b0;
      started   = 1'b1;
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        q0.delete();
        q1.delete();
        since_restart = 0;
        exp_fault = 1'b1;
      end else begin
        restart(redirect_target, redirect_target);
        exp_fault = 1'b0;
      end
`else
      restart({redirect_target[31:2], 2'b00}, {redirect_target[31:2], 2'b00});
`endif
    end
    reset           = rst;
    fetch_enable    = en;
    if_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] pc,
                     input logic [31:0] ins, input logic ff);
    logic [31:0] e;
    if (redirect_valid === 1'b1) chk($sformatf("valid_in_redirect%0d", d), {31'b0, v}, 32'd0);
    chk($sformatf("fault%0d", d), {31'b0, ff}, {31'b0, exp_fault});
    if (prev_stall[d] && !prev_rst && redirect_valid !== 1'b1) begin
      chk($sformatf("stall_valid%0d", d), {31'b0, v}, 32'd1);
      chk($sformatf("stall_pc%0d", d), pc, prev_pc[d]);
      chk($sformatf("stall_instr%0d", d), ins, prev_ins[d]);
    end
    if (v === 1'b1 && if_ready === 1'b1) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_handshake%0d: got pc %h, expected no transfer", d, pc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("pc%0d", d), pc, e);
        chk($sformatf("instr%0d", d), ins, mem_f(e));
      end
    end
    prev_stall[d] = (v === 1'b1) && (if_ready === 1'b0);
    prev_pc[d]    = pc;
    prev_ins[d]   = ins;
  endtask

  // Scoreboard monitor: compares every handshake and output invariant.
  always @(negedge clk) begin
    if (started) begin
      mon(0, bus0.if_valid, bus0.if_pc, bus0.if_instruction, bus0.fetch_fault);
      mon(1, bus1.if_valid, bus1.if_pc, bus1.if_instruction, bus1.fetch_fault);
    end
    prev_rst = reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    bit          rst, rv;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;

    // Reset values, then streaming with decode always ready.
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("rst_valid0", {31'b0, bus0.if_valid}, 32'd0);
    chk("rst_valid1", {31'b0, bus1.if_valid}, 32'd0);
    chk("rst_addr0", bus0.imem_address, RV0);
    chk("rst_addr1", bus1.imem_address, RV1);
    chk("rst_fault0", {31'b0, bus0.fetch_fault}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 1, 0, 0);
      @(negedge clk);
      chk("stream_valid0", {31'b0, bus0.if_valid}, 32'd1);
      chk("stream_pc0", bus0.if_pc, RV0 + 32'(4 * k));
      chk("stream_pc1", bus1.if_pc, RV1 + 32'(4 * k));
    end

    // Backpressure straight out of reset: buffer fills, pc holds.
    cycle(1, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("bp_addr0", bus0.imem_address, 32'h8);
    chk("bp_head0", bus0.if_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 1, 0, 0);
      @(negedge clk);
      chk("bp_release_pc0", bus0.if_pc, 32'(4 * k));
    end

    // Redirect while full.
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'h40);
    @(negedge clk);
    chk("redir_n_valid0", {31'b0, bus0.if_valid}, 32'd0);
    cycle(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("redir_n1_valid0", {31'b0, bus0.if_valid}, 32'd0);
    cycle(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("redir_n2_valid0", {31'b0, bus0.if_valid}, 32'd1);
    chk("redir_n2_pc0", bus0.if_pc, 32'h40);
    chk("redir_n2_pc1", bus1.if_pc, 32'h40);

    // Misaligned redirect, then an aligned one.
    cycle(0, 1, 1, 1, 32'h42);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault0", {31'b0, bus0.fetch_fault}, 32'd1);
    chk("mis_valid0", {31'b0, bus0.if_valid}, 32'd0);
    chk("mis_addr0", bus0.imem_address, 32'h42);
`else
    chk("mis_fault0", {31'b0, bus0.fetch_fault}, 32'd0);
    chk("mis_valid0", {31'b0, bus0.if_valid}, 32'd1);
    chk("mis_pc0", bus0.if_pc, 32'h40);
`endif
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h80);
    cycle(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("clr_fault0", {31'b0, bus0.fetch_fault}, 32'd0);
    cycle(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("clr_pc0", bus0.if_pc, 32'h80);

    // Reset with full buffer and a redirect in the same cycle.
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'h100);
    cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_valid0", {31'b0, bus0.if_valid}, 32'd0);
    chk("mid_rst_addr0", bus0.imem_address, RV0);
    chk("mid_rst_addr1", bus1.imem_address, RV1);
    chk("mid_rst_fault0", {31'b0, bus0.fetch_fault}, 32'd0);

    // Randomized traffic, checked by the scoreboard monitor.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0) || (since_restart > 150);
      case ($urandom_range(0, 9))
        0:       tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        1:       tgt = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
        default: tgt = $urandom & 32'h0000_0FFC;
      endcase
      cycle(rst, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, rv, tgt);
    end
    cycle(0, 1, 1, 1, 32'h200);
    for (int k = 0; k < 10; k++) cycle(0, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
